// File: rtl/axi4lite_sram_slave_if.sv
// AXI4-Lite bus bundle between the core's master port and the SRAM slave.
// Signal names follow the bus naming used across the core.
interface axi4lite_sram_slave_if;
  logic [31:0] AWdata;
  logic        AWvalid;
  logic        AWready;
  logic [2:0]  AWprot;
  logic [31:0] Wdata;
  logic [3:0]  Wstrb;
  logic        Wvalid;
  logic        Wready;
  logic        Bvalid;
  logic        Bready;
  logic [31:0] ARdata;
  logic        ARvalid;
  logic        ARready;
  logic [2:0]  ARprot;
  logic [31:0] Rdata;
  logic        Rvalid;
  logic        Rready;

  modport slave (
    input  AWdata, AWvalid, AWprot, Wdata, Wstrb, Wvalid, Bready,
    input  ARdata, ARvalid, ARprot, Rready,
    output AWready, Wready, Bvalid, ARready, Rdata, Rvalid
  );

  modport master (
    output AWdata, AWvalid, AWprot, Wdata, Wstrb, Wvalid, Bready,
    output ARdata, ARvalid, ARprot, Rready,
    input  AWready, Wready, Bvalid, ARready, Rdata, Rvalid
  );
endinterface

// File: rtl/axi4lite_sram_slave.sv
// Word-addressed single-port SRAM behind an AXI4-Lite slave with independent read/write FSMs.
// Optional wait-state insertion is enabled by defining AXI_SRAM_WAIT_EN.
module axi4lite_sram_slave #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  axi4lite_sram_slave_if.slave bus
);

  localparam int unsigned DEPTH_C = 1 << ADDR_WIDTH;

`ifdef AXI_SRAM_WAIT_EN
  localparam bit          WAIT_EN_C = (WAIT_CYCLES > 0);
  localparam int unsigned CNT_W_C   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {W_COLLECT = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_e;
`else
  typedef enum logic [1:0] {W_COLLECT = 2'd0, W_RESP = 2'd2} w_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_DATA = 2'd2} r_state_e;
`endif

  // Byte address to word index; low two bits and high bits wrap away.
  function automatic logic [ADDR_WIDTH-1:0] word_idx(input logic [31:0] addr);
    return addr[ADDR_WIDTH+1:2];
  endfunction

  logic [31:0]           mem_r [DEPTH_C];

  w_state_e              w_state_r, w_state_s;
  logic                  aw_held_r, aw_held_s;
  logic                  w_held_r, w_held_s;
  logic [ADDR_WIDTH-1:0] aw_idx_r, aw_idx_s;
  logic [31:0]           wdata_r, wdata_s;
  logic [3:0]            wstrb_r, wstrb_s;
  logic                  aw_ready_r, aw_ready_s;
  logic                  w_ready_r, w_ready_s;
  logic                  bvalid_r, bvalid_s;
  logic                  commit_s;
  logic                  aw_hs_s, w_hs_s;

  r_state_e              r_state_r, r_state_s;
  logic [ADDR_WIDTH-1:0] ar_idx_r, ar_idx_s;
  logic                  ar_ready_r, ar_ready_s;
  logic                  rvalid_r, rvalid_s;
  logic [31:0]           rdata_r;
  logic                  rload_s;
  logic                  ar_hs_s;

`ifdef AXI_SRAM_WAIT_EN
  logic [CNT_W_C-1:0]    w_cnt_r, w_cnt_s;
  logic [CNT_W_C-1:0]    r_cnt_r, r_cnt_s;
`endif

  logic                  unused_s;
  assign unused_s = ^{bus.AWprot, bus.ARprot, bus.AWdata, bus.ARdata, 32'(WAIT_CYCLES)};

  assign aw_hs_s = bus.AWvalid & aw_ready_r;
  assign w_hs_s  = bus.Wvalid & w_ready_r;
  assign ar_hs_s = bus.ARvalid & ar_ready_r;

  assign bus.AWready = aw_ready_r;
  assign bus.Wready  = w_ready_r;
  assign bus.Bvalid  = bvalid_r;
  assign bus.ARready = ar_ready_r;
  assign bus.Rvalid  = rvalid_r;
  assign bus.Rdata   = rdata_r;

  // Write channel next-state: collect AW and W in any order, optionally wait, commit, respond.
  always_comb begin
    w_state_s = w_state_r;
    aw_held_s = aw_held_r;
    w_held_s  = w_held_r;
    aw_idx_s  = aw_idx_r;
    wdata_s   = wdata_r;
    wstrb_s   = wstrb_r;
    commit_s  = 1'b0;
`ifdef AXI_SRAM_WAIT_EN
    w_cnt_s   = w_cnt_r;
`endif
    case (w_state_r)
      W_COLLECT: begin
        if (aw_hs_s) begin
          aw_held_s = 1'b1;
          aw_idx_s  = word_idx(bus.AWdata);
        end else begin
          aw_held_s = aw_held_r;
        end
        if (w_hs_s) begin
          w_held_s = 1'b1;
          wdata_s  = bus.Wdata;
          wstrb_s  = bus.Wstrb;
        end else begin
          w_held_s = w_held_r;
        end
        if (aw_held_s && w_held_s) begin
`ifdef AXI_SRAM_WAIT_EN
          if (WAIT_EN_C) begin
            w_state_s = W_WAIT;
            w_cnt_s   = CNT_W_C'(WAIT_CYCLES);
          end else begin
            commit_s  = 1'b1;
            w_state_s = W_RESP;
          end
`else
          commit_s  = 1'b1;
          w_state_s = W_RESP;
`endif
        end else begin
          w_state_s = W_COLLECT;
        end
      end
`ifdef AXI_SRAM_WAIT_EN
      W_WAIT: begin
        if (w_cnt_r == CNT_W_C'(1)) begin
          commit_s  = 1'b1;
          w_state_s = W_RESP;
        end else begin
          w_cnt_s = w_cnt_r - CNT_W_C'(1);
        end
      end
`endif
      W_RESP: begin
        if (bvalid_r && bus.Bready) begin
          aw_held_s = 1'b0;
          w_held_s  = 1'b0;
          w_state_s = W_COLLECT;
        end else begin
          w_state_s = W_RESP;
        end
      end
      default: begin
        aw_held_s = 1'b0;
        w_held_s  = 1'b0;
        w_state_s = W_COLLECT;
      end
    endcase
    aw_ready_s = (w_state_s == W_COLLECT) & ~aw_held_s;
    w_ready_s  = (w_state_s == W_COLLECT) & ~w_held_s;
    bvalid_s   = (w_state_s == W_RESP);
  end

  // Write channel state, payload latches and registered handshake outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_r  <= W_COLLECT;
      aw_held_r  <= 1'b0;
      w_held_r   <= 1'b0;
      aw_idx_r   <= '0;
      wdata_r    <= 32'd0;
      wstrb_r    <= 4'd0;
      aw_ready_r <= 1'b0;
      w_ready_r  <= 1'b0;
      bvalid_r   <= 1'b0;
    end else begin
      w_state_r  <= w_state_s;
      aw_held_r  <= aw_held_s;
      w_held_r   <= w_held_s;
      aw_idx_r   <= aw_idx_s;
      wdata_r    <= wdata_s;
      wstrb_r    <= wstrb_s;
      aw_ready_r <= aw_ready_s;
      w_ready_r  <= w_ready_s;
      bvalid_r   <= bvalid_s;
    end
  end

  // Read channel next-state: accept address, optionally wait, present data until taken.
  always_comb begin
    r_state_s = r_state_r;
    ar_idx_s  = ar_idx_r;
    rload_s   = 1'b0;
`ifdef AXI_SRAM_WAIT_EN
    r_cnt_s   = r_cnt_r;
`endif
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          ar_idx_s = word_idx(bus.ARdata);
`ifdef AXI_SRAM_WAIT_EN
          if (WAIT_EN_C) begin
            r_state_s = R_WAIT;
            r_cnt_s   = CNT_W_C'(WAIT_CYCLES);
          end else begin
            rload_s   = 1'b1;
            r_state_s = R_DATA;
          end
`else
          rload_s   = 1'b1;
          r_state_s = R_DATA;
`endif
        end else begin
          r_state_s = R_IDLE;
        end
      end
`ifdef AXI_SRAM_WAIT_EN
      R_WAIT: begin
        if (r_cnt_r == CNT_W_C'(1)) begin
          rload_s   = 1'b1;
          r_state_s = R_DATA;
        end else begin
          r_cnt_s = r_cnt_r - CNT_W_C'(1);
        end
      end
`endif
      R_DATA: begin
        if (rvalid_r && bus.Rready) begin
          r_state_s = R_IDLE;
        end else begin
          r_state_s = R_DATA;
        end
      end
      default: begin
        r_state_s = R_IDLE;
      end
    endcase
    ar_ready_s = (r_state_s == R_IDLE);
    rvalid_s   = (r_state_s == R_DATA);
  end

  // Read channel state and registered outputs; Rdata samples the array before any same-edge commit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_r  <= R_IDLE;
      ar_idx_r   <= '0;
      ar_ready_r <= 1'b0;
      rvalid_r   <= 1'b0;
      rdata_r    <= 32'd0;
    end else begin
      r_state_r  <= r_state_s;
      ar_idx_r   <= ar_idx_s;
      ar_ready_r <= ar_ready_s;
      rvalid_r   <= rvalid_s;
      if (rload_s) begin
        rdata_r <= mem_r[ar_idx_s];
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

`ifdef AXI_SRAM_WAIT_EN
  // Wait-state down-counters for both channels.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_cnt_r <= '0;
      r_cnt_r <= '0;
    end else begin
      w_cnt_r <= w_cnt_s;
      r_cnt_r <= r_cnt_s;
    end
  end
`endif

  // Byte-strobed array write; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_s[b]) begin
          mem_r[aw_idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: doc/axi4lite_sram_slave.md
# axi4lite_sram_slave

- Single-port word-addressed SRAM behind an AXI4-Lite slave interface.
- Sits directly downstream of the core's AXI4-Lite master port. Serves both instruction fetches and load/store traffic.
- Independent read and write channel FSMs, byte-strobed writes, optional wait-state insertion to emulate slow memory.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, extra latency cycles per access. Used only when the wait-state macro is defined.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  clock, all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- AWdata  input  32  write byte address
- AWvalid  input  1  write address valid
- AWready  output  1  write address accepted
- AWprot  input  3  ignored
- Wdata  input  32  write data
- Wstrb  input  4  byte enables; bit i enables Wdata[8i+7:8i]
- Wvalid  input  1  write data valid
- Wready  output  1  write data accepted
- Bvalid  output  1  write response valid (response is always OKAY)
- Bready  input  1  write response accepted
- ARdata  input  32  read byte address
- ARvalid  input  1  read address valid
- ARready  output  1  read address accepted
- ARprot  input  3  ignored
- Rdata  output  32  read data
- Rvalid  output  1  read data valid
- Rready  input  1  read data accepted

## Operation

**Address decode**
- Word index = addr[ADDR_WIDTH+1:2].
- addr[1:0] and bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo 4·2^ADDR_WIDTH.

**Write FSM: W_COLLECT → W_WAIT → W_RESP**
- W_COLLECT
  - AWready = ~aw_held; Wready = ~w_held.
  - Each handshake latches its payload and sets its held flag. Both channels may handshake in the same cycle or in either order.
  - When both are held, or complete in the current cycle: go to W_WAIT if wait states are enabled and WAIT_CYCLES>0, else commit and go to W_RESP.
- W_WAIT
  - Down-counter loaded with WAIT_CYCLES; AWready = Wready = 0.
  - At count 1: commit and go to W_RESP.
- Commit
  - Each byte with Wstrb bit set is written on the edge entering W_RESP; other bytes are unchanged.
  - Wstrb = 0 still produces a response.
- W_RESP
  - Bvalid = 1 until Bvalid & Bready, then clear held flags and return to W_COLLECT.

**Read FSM: R_IDLE → R_WAIT → R_DATA**
- R_IDLE: ARready = 1. On handshake, latch the address and go to R_WAIT, or straight to R_DATA when there are no wait states.
- R_DATA
  - Rdata is loaded from the array on the entering edge.
  - Rvalid = 1 and Rdata holds stable until Rvalid & Rready, then return to R_IDLE.

**Concurrency**
- Read and write channels are fully independent.
- If a write commit and a read data load hit the same word on the same edge, the read returns the pre-write data.

**Storage**
- The memory array is not reset.

## Timing
- Reset values: AWready = Wready = ARready = 0, Bvalid = Rvalid = 0, Rdata = 0, held flags cleared, both FSMs at their initial state.
- Readies rise on the first rising edge after rstn deasserts.
- Reset mid-operation:
  - Aborts immediately.
  - An uncommitted write is discarded; committed data is retained.
- Write latency: last of the AW/W handshakes in cycle N → Bvalid high in cycle N+1 (+WAIT_CYCLES). The array is updated on the same edge.
- Read latency: AR handshake in cycle N → Rvalid and valid Rdata in cycle N+1 (+WAIT_CYCLES).
- Back-to-back throughput:
  - B or R handshake in cycle M → corresponding readies high in cycle M+1.
  - Peak rate is one access per 2 cycles per channel (without wait states).
- Bvalid and Rvalid never drop without a handshake. Wait states also apply when Bready or Rready is held high.

## Configuration
- Macro: AXI_SRAM_WAIT_EN.
- Defined: the W_WAIT and R_WAIT states and the counter exist, and every access takes WAIT_CYCLES extra cycles. WAIT_CYCLES = 0 behaves as undefined.
- Undefined: wait states, counter and WAIT_CYCLES usage are compiled out; latency is fixed at 1 cycle.

## Test plan
- Reset, write/read round trip:
  - Stimulus: rstn low 3 cycles; after release, AW = 0x0000_0010 and W = 0xDEAD_BEEF with Wstrb = 0xF, same cycle.
  - Required: Bvalid the next cycle.
  - Then AR = 0x10 → Rdata = 0xDEAD_BEEF, Rvalid one cycle after the AR handshake (macro off).
- Byte strobes: word 0x20 = 0x1122_3344; write 0xAABB_CCDD with Wstrb = 0b0101 → read returns 0x11BB_33DD.
- Split and backpressured channels:
  - W handshake 3 cycles before AW → write commits only after AW; Wready stays 0 in between.
  - Bready held low 4 cycles → Bvalid stays 1 and AWready stays 0 throughout.
- Wrap and collision:
  - Write 0x5A5A_5A5A to address 4·2^ADDR_WIDTH + 8 → read of address 0x8 returns 0x5A5A_5A5A.
  - Simultaneous read and write commit to the same word → read returns the old value.
- Wait states and abort:
  - With AXI_SRAM_WAIT_EN and WAIT_CYCLES = 2: read latency is 3 cycles.
  - rstn pulsed during W_WAIT → Bvalid stays 0 and the target word is unchanged.
